hilo_unit: RTL and testbench
============================

# hilo_unit

Multi-cycle multiply/divide sequencer and HI/LO register pair for the MIPS CPU datapath. It sits directly downstream of the combinational `divider`: it latches operands, drives them onto the divider for a fixed multicycle window, and captures quotient and remainder into LO and HI. It also computes MULT/MULTU products internally and services MTHI/MTLO writes. While an operation is in flight it raises `busy` so the pipeline controller can stall.

## Interface
Parameters:
- `MUL_CYCLES`, default 2: cycles from accepted MULT/MULTU to HI/LO write; must be ≥1.
- `DIV_CYCLES`, default 4: cycles the divider path is given before HI/LO capture; must be ≥1.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: qualifies `op` for one cycle.
- `op` in 3: 3'd1 MULT, 3'd2 MULTU, 3'd3 DIV, 3'd4 DIVU, 3'd5 MTHI, 3'd6 MTLO; all other codes are no-ops.
- `rs_val` in 32: operand A, or write data for MTHI/MTLO.
- `rt_val` in 32: operand B.
- `div_a` out 32: latched dividend to the divider.
- `div_b` out 32: latched divisor to the divider.
- `div_signed` out 1: divider `instr` input; 1 for DIV, 0 for DIVU.
- `div_lo` in 32: quotient from the divider.
- `div_hi` in 32: remainder from the divider.
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse after HI/LO are updated by MULT/MULTU/DIV/DIVU.
- `div0` out 1: one-cycle divide-by-zero pulse (see Configuration).
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- States: IDLE, MUL, DIV.
- IDLE with `start` and MULT/MULTU:
  - Latch operands into `op_a` and `op_b`, and latch signedness.
  - Load `cnt = MUL_CYCLES-1`; go to MUL.
- IDLE with `start` and DIV/DIVU:
  - Latch operands into `div_a` and `div_b`; set `div_signed`.
  - Load `cnt = DIV_CYCLES-1`; go to DIV.
- IDLE with `start` and MTHI/MTLO: write `rs_val` to HI or LO at that edge. State stays IDLE and there is no `busy`.
- MUL/DIV with `cnt != 0`: decrement `cnt`.
- MUL with `cnt == 0`:
  - Write the 64-bit product, `{hi,lo}`. MULT sign-extends both operands to 64 bits; MULTU zero-extends them.
  - Go to IDLE.
- DIV with `cnt == 0`:
  - `lo <= div_lo`, `hi <= div_hi`; go to IDLE.
- `done` is registered: it is high in the cycle after the HI/LO write.
- `start` while `busy`: ignored completely, including MTHI/MTLO. The controller must stall.
- `div_a`, `div_b` and `div_signed` hold their value until the next accepted DIV/DIVU, so the combinational divider sees stable inputs for the whole window.
- Overflow: DIV of 0x80000000 by 0xFFFFFFFF captures whatever the divider returns; no special handling.

## Timing
- Reset values: `hi`, `lo`, `div_a`, `div_b` = 0; `div_signed`, `busy`, `done`, `div0` = 0; state IDLE, `cnt` = 0.
- `busy` is registered. It rises in the cycle after `start` is accepted and stays high for exactly N cycles, where N = `MUL_CYCLES` or `DIV_CYCLES`.
- The HI/LO write happens on the edge that ends the last `busy` cycle.
- New HI/LO values are visible on `hi`/`lo` in the same cycle `done` is high.
- Back-to-back operation: `start` in the `done` cycle is accepted, because state is IDLE there.
- MTHI/MTLO latency is 1 edge.
- `rst_n` low at any edge, mid-operation included:
  - Abort the operation; HI/LO return to 0.
  - No `done`, no `div0`.

## Configuration
- `HILO_DIV0_TRAP_EN` defined:
  - DIV/DIVU with latched `div_b == 0` leaves HI/LO unchanged at the final edge.
  - `div0` pulses together with `done`.
- `HILO_DIV0_TRAP_EN` undefined:
  - HI/LO capture the divider outputs unconditionally.
  - `div0` is tied to 0.

## Test plan
- MULT, `rs_val`=0xFFFFFFFE (-2), `rt_val`=3, default params -> `busy` high for 2 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA, `done` pulses once.
- MULTU with the same operands -> `hi`=0x00000002, `lo`=0xFFFFFFFA.
- DIV -2 / 2 with the real `divider` attached -> `div_signed`=1 during the window; 4 busy cycles; `lo`=0xFFFFFFFF, `hi`=0. DIVU 7 / 2 -> `lo`=3, `hi`=1.
- MTHI 0x12345678, then MTLO 0xA5A5A5A5 on the next cycle -> `hi` and `lo` each update after 1 edge; `busy` stays 0.
- During DIV busy, pulse `start` with MTLO 0xDEADBEEF -> ignored: `lo` ends at the DIV quotient, not 0xDEADBEEF.
- DIVU 5 / 0 with `HILO_DIV0_TRAP_EN` defined, preloaded `hi`=1, `lo`=2 -> HI/LO stay 1 and 2; `div0` and `done` pulse together. Separately, assert `rst_n`=0 in the 2nd busy cycle of a DIV -> next cycle `busy`=0, `hi`=`lo`=0, no `done`.

Source files
------------

// File: rtl/hilo_unit.sv
// HI/LO register pair with a multi-cycle MULT/MULTU/DIV/DIVU sequencer that feeds an external
// combinational divider. Optional divide-by-zero trap is enabled by defining HILO_DIV0_TRAP_EN.
module hilo_unit #(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_signed,
    input  logic [31:0] div_lo,
    input  logic [31:0] div_hi,
    output logic        busy,
    output logic        done,
    output logic        div0,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t      state;
    logic [31:0] cnt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        mul_signed;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;
    logic        div_trap;

    // Low 64 bits of the product of the extended operands are correct for both signednesses.
    always_comb begin
        a_ext   = mul_signed ? {{32{op_a[31]}}, op_a} : {32'b0, op_a};
        b_ext   = mul_signed ? {{32{op_b[31]}}, op_b} : {32'b0, op_b};
        product = a_ext * b_ext;
    end

`ifdef HILO_DIV0_TRAP_EN
    always_comb div_trap = (div_b == 32'd0);
`else
    always_comb div_trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 32'd0;
            op_a       <= 32'd0;
            op_b       <= 32'd0;
            mul_signed <= 1'b0;
            div_a      <= 32'd0;
            div_b      <= 32'd0;
            div_signed <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            div0       <= 1'b0;
            hi         <= 32'd0;
            lo         <= 32'd0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OpMult, OpMultu: begin
                                op_a       <= rs_val;
                                op_b       <= rt_val;
                                mul_signed <= (op == OpMult);
                                cnt        <= 32'(MUL_CYCLES - 1);
                                busy       <= 1'b1;
                                state      <= MUL;
                            end
                            OpDiv, OpDivu: begin
                                div_a      <= rs_val;
                                div_b      <= rt_val;
                                div_signed <= (op == OpDiv);
                                cnt        <= 32'(DIV_CYCLES - 1);
                                busy       <= 1'b1;
                                state      <= DIV;
                            end
                            OpMthi:  hi <= rs_val;
                            OpMtlo:  lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (cnt != 32'd0) begin
                        cnt <= cnt - 32'd1;
                    end else begin
                        {hi, lo} <= product;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end
                end
                DIV: begin
                    if (cnt != 32'd0) begin
                        cnt <= cnt - 32'd1;
                    end else begin
                        // A trapped divide by zero leaves HI/LO untouched.
                        if (!div_trap) begin
                            hi <= div_hi;
                            lo <= div_lo;
                        end
                        div0  <= div_trap;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit with a behavioural stand-in for the combinational divider.
// Divide by zero in the stand-in yields quotient all-ones and remainder equal to the dividend.
module tb_hilo_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_signed;
    logic [31:0] div_lo;
    logic [31:0] div_hi;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hilo_unit #(
        .MUL_CYCLES(2),
        .DIV_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_signed(div_signed),
        .div_lo    (div_lo),
        .div_hi    (div_hi),
        .busy      (busy),
        .done      (done),
        .div0      (div0),
        .hi        (hi),
        .lo        (lo)
    );

    always_comb begin
        div_lo = 32'hFFFF_FFFF;
        div_hi = div_a;
        if (div_b != 32'd0) begin
            if (div_signed) begin
                div_lo = $signed(div_a) / $signed(div_b);
                div_hi = $signed(div_a) % $signed(div_b);
            end else begin
                div_lo = div_a / div_b;
                div_hi = div_a % div_b;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        tick();
        start  = 1'b0;
        op     = 3'd0;
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 3'd0;
        rs_val = 32'd0;
        rt_val = 32'd0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_ctl", {61'd0, busy, done, div0}, 64'd0);
        check("rst_div", {div_a, div_b}, 64'd0);
        check("rst_div_signed", 64'(div_signed), 64'd0);

        // MULT -2 * 3
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        check("mult_busy1", {62'd0, busy, done}, 64'd2);
        tick();
        check("mult_busy2", {62'd0, busy, done}, 64'd2);
        tick();
        check("mult_done", {62'd0, busy, done}, 64'd1);
        check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        tick();
        check("mult_done_pulse", 64'(done), 64'd0);

        // MULTU same operands
        issue(3'd2, 32'hFFFF_FFFE, 32'd3);
        tick();
        tick();
        check("multu_done", {62'd0, busy, done}, 64'd1);
        check("multu_hilo", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
        tick();

        // DIV -2 / 2
        issue(3'd3, 32'hFFFF_FFFE, 32'd2);
        check("div_signed_set", 64'(div_signed), 64'd1);
        check("div_operands", {div_a, div_b}, 64'hFFFF_FFFE_0000_0002);
        for (int i = 0; i < 3; i++) begin
            check("div_busy", {62'd0, busy, done}, 64'd2);
            tick();
        end
        check("div_busy4", {62'd0, busy, done}, 64'd2);
        tick();
        check("div_done", {62'd0, busy, done}, 64'd1);
        check("div_hilo", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
        tick();

        // DIVU 7 / 2 with an MTLO issued mid-flight that must be ignored
        issue(3'd4, 32'd7, 32'd2);
        check("divu_signed_clr", 64'(div_signed), 64'd0);
        issue(3'd6, 32'hDEAD_BEEF, 32'd0);
        check("divu_mtlo_ignored", 64'(lo), 64'hFFFF_FFFF);
        tick();
        tick();
        check("divu_busy4", 64'(busy), 64'd1);
        tick();
        check("divu_done", {62'd0, busy, done}, 64'd1);
        check("divu_hilo", {hi, lo}, 64'h0000_0001_0000_0003);

        // MTHI in the done cycle, then MTLO
        issue(3'd5, 32'h1234_5678, 32'd0);
        check("mthi_hi", 64'(hi), 64'h1234_5678);
        check("mthi_lo_kept", 64'(lo), 64'd3);
        check("mthi_busy", {62'd0, busy, done}, 64'd0);
        issue(3'd6, 32'hA5A5_A5A5, 32'd0);
        check("mtlo_hilo", {hi, lo}, 64'h1234_5678_A5A5_A5A5);
        check("mtlo_busy", 64'(busy), 64'd0);

        // DIVU 5 / 0 with HI=1, LO=2 preloaded
        issue(3'd5, 32'd1, 32'd0);
        issue(3'd6, 32'd2, 32'd0);
        issue(3'd4, 32'd5, 32'd0);
        tick();
        tick();
        tick();
        check("div0_quiet", 64'(div0), 64'd0);
        tick();
`ifdef HILO_DIV0_TRAP_EN
        check("div0_hilo", {hi, lo}, 64'h0000_0001_0000_0002);
        check("div0_pulse", {62'd0, done, div0}, 64'd3);
`else
        check("div0_hilo", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
        check("div0_pulse", {62'd0, done, div0}, 64'd2);
`endif
        tick();
        check("div0_clear", {62'd0, done, div0}, 64'd0);

        // Reset in the second busy cycle of a DIV
        issue(3'd3, 32'd100, 32'd7);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid_ctl", {61'd0, busy, done, div0}, 64'd0);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_mid_no_done", {62'd0, done, busy}, 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
